// File: rtl/z_queue_pkg.sv
// Shared types for the Z move queue: FSM states, handshake timeout and FIFO entry layout.
package z_queue_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    RUN
  } zq_state_e;

  // Cycles the queue waits in WAIT_ACK for the stepper to report driving.
  localparam int ACK_TIMEOUT = 2;

  // One queued move: raw step command plus the already-clamped half-period.
  typedef struct packed {
    logic [31:0] step;
    logic [31:0] speed;
  } zq_entry_t;

endpackage

// File: rtl/z_move_queue_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x 64 bits, with occupancy output and single-cycle flush.
module cmd_fifo
  import z_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  zq_entry_t                wr_data,
  input  logic                     rd_en,
  output zq_entry_t                rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  zq_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] wr_ptr_d;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] rd_ptr_d;
  logic        do_wr;
  logic        do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == DEPTH_W);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  // Next-pointer logic; flush overrides any write or read in the same cycle.
  always_comb begin
    do_wr    = wr_en & ~full & ~flush;
    do_rd    = rd_en & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Entry storage holds data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/z_move_queue.sv
// Z-axis move queue: buffers move commands and dispatches them one at a time to the
// downstream Z stepper, tracking completions and latching an abort with residual steps.
module z_move_queue
  import z_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MIN_SPEED = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             cmd_step,
  input  logic [31:0]             cmd_speed,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    flush,
  input  logic                    stepper_driving,
  input  logic [31:0]             stepper_step_out,
  input  logic                    zmin,
  input  logic                    zmax,
  output logic [31:0]             stepper_step_in,
  output logic [31:0]             stepper_speed,
  output logic                    start_driving,
  output logic                    busy,
  output logic                    abort,
  output logic [31:0]             residual,
  output logic [15:0]             done_count,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam logic [31:0] MIN_SPEED_W = 32'(MIN_SPEED);
  localparam logic [1:0]  ACK_LAST    = 2'(ACK_TIMEOUT - 1);

  // Saturate the requested half-period from below so the stepper never sees 0.
  function automatic logic [31:0] clamp_speed(input logic [31:0] spd);
    return (spd < MIN_SPEED_W) ? MIN_SPEED_W : spd;
  endfunction

  zq_state_e   state_q, state_d;
  logic [1:0]  ack_cnt_q, ack_cnt_d;
  logic [31:0] step_in_q, step_in_d;
  logic [31:0] speed_q, speed_d;
  logic        start_q, start_d;
  logic        abort_q, abort_d;
  logic [31:0] residual_q, residual_d;
  logic [15:0] done_q, done_d;
  logic        rdy_en_q, rdy_en_d;

  zq_entry_t   wr_entry;
  zq_entry_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        wr_en;
  logic        pop;

  // Endstops are enforced by the stepper itself; the queue only sees their effect
  // through stepper_driving and the remaining count in stepper_step_out.
  logic        unused_endstops;
  assign unused_endstops = zmin ^ zmax;

  // rdy_en_q keeps cmd_ready low while reset is held and until the first clock after it.
  assign cmd_ready        = rdy_en_q & ~fifo_full & ~abort_q;
  assign wr_en            = cmd_valid & cmd_ready;
  assign busy             = (state_q != IDLE) | (~fifo_empty & ~abort_q);
  assign abort            = abort_q;
  assign residual         = residual_q;
  assign done_count       = done_q;
  assign stepper_step_in  = step_in_q;
  assign stepper_speed    = speed_q;
  assign start_driving    = start_q;

  // Build the FIFO entry with the speed already clamped.
  always_comb begin
    wr_entry.step  = cmd_step;
    wr_entry.speed = clamp_speed(cmd_speed);
  end

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Dispatch FSM next-state and output logic; flush clears abort and also
  // suppresses any abort the current move would raise on the same cycle.
  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = ack_cnt_q;
    step_in_d  = step_in_q;
    speed_d    = speed_q;
    abort_d    = abort_q;
    residual_d = residual_q;
    done_d     = done_q;
    rdy_en_d   = 1'b1;
    pop        = 1'b0;
    if (flush) abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !abort_q && !flush && !stepper_driving) state_d = LOAD;
      end
      LOAD: begin
        pop       = 1'b1;
        step_in_d = head.step;
        speed_d   = head.speed;
        if (head.step[30:0] == '0) begin
          done_d  = done_q + 16'd1;
          state_d = IDLE;
        end else begin
          state_d = START;
        end
      end
      START: begin
        ack_cnt_d = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (stepper_driving) begin
          state_d = RUN;
        end else if (ack_cnt_q == ACK_LAST) begin
          state_d = IDLE;
          if (!flush) begin
            abort_d    = 1'b1;
            residual_d = step_in_q;
          end
        end else begin
          ack_cnt_d = ack_cnt_q + 2'd1;
        end
      end
      RUN: begin
        if (!stepper_driving) begin
          state_d = IDLE;
          if (stepper_step_out[30:0] == '0) begin
            done_d = done_q + 16'd1;
          end else if (!flush) begin
            abort_d    = 1'b1;
            residual_d = stepper_step_out;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == START);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ack_cnt_q  <= '0;
      step_in_q  <= '0;
      speed_q    <= MIN_SPEED_W;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      residual_q <= '0;
      done_q     <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_cnt_q  <= ack_cnt_d;
      step_in_q  <= step_in_d;
      speed_q    <= speed_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      residual_q <= residual_d;
      done_q     <= done_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

endmodule

// File: doc/z_move_queue.md
Z_MOVE_QUEUE -- requirements
Module: z_move_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, command FIFO depth (power of two, 2..64).
REQ-002 SHALL have parameter MIN_SPEED, default 1, minimum half-period in clocks forwarded to the stepper.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_step  in  32  move command: bit31 = dir, [30:0] = step count; if bit31=1, [30:0] is the two's-complement negative count.
REQ-006 SHALL have port cmd_speed  in  32  half-period of step signal, in clocks.
REQ-007 SHALL have ports cmd_valid  in  1 and cmd_ready  out  1  write handshake.
REQ-008 SHALL have port flush  in  1  single-cycle request to empty the FIFO and clear abort.
REQ-009 SHALL have ports stepper_driving  in  1, stepper_step_out  in  32, zmin  in  1, zmax  in  1  status from the downstream Z stepper.
REQ-010 SHALL have ports stepper_step_in  out  32, stepper_speed  out  32, start_driving  out  1  command to the downstream Z stepper.
REQ-011 SHALL have ports busy  out  1, abort  out  1, residual  out  32, done_count  out  16, fifo_level  out  clog2(DEPTH)+1.

Function
REQ-012 SHALL accept a command on a clk edge where cmd_valid & cmd_ready; cmd_ready = ~full & ~abort.
REQ-013 SHALL store {cmd_step, clamped speed} per entry; clamped speed = MIN_SPEED when cmd_speed < MIN_SPEED, else cmd_speed.
REQ-014 SHALL implement FSM states IDLE, LOAD, START, WAIT_ACK, RUN.
REQ-015 IDLE -> LOAD when FIFO non-empty, ~abort, ~stepper_driving; LOAD pops one entry and registers stepper_step_in/stepper_speed.
REQ-016 LOAD: if popped count [30:0] == 0, SHALL increment done_count and return to IDLE without asserting start_driving; else -> START.
REQ-017 START SHALL assert start_driving for exactly one cycle; stepper_step_in/stepper_speed held stable from LOAD until RUN exits.
REQ-018 WAIT_ACK: stepper_driving=1 within 2 cycles -> RUN; otherwise (endstop blocked start) -> abort set, residual = stepper_step_in, IDLE.
REQ-019 RUN -> IDLE on stepper_driving falling; if stepper_step_out[30:0]==0, done_count +1 (wraps at 16 bits); else abort set, residual = stepper_step_out.
REQ-020 busy SHALL be 1 in any state other than IDLE, or when FIFO non-empty and ~abort.
REQ-021 flush SHALL empty FIFO and clear abort in one cycle, any state; an in-flight move (START/WAIT_ACK/RUN) completes normally but cannot set abort if flush coincides with its exit.
REQ-022 Simultaneous write and flush: flush wins, the write is discarded.
REQ-023 Simultaneous write and pop: both occur, fifo_level unchanged; write when full is ignored.
REQ-024 abort SHALL stay set until flush or reset; residual holds until next abort.

Reset
REQ-025 reset_n low SHALL asynchronously force: state IDLE, FIFO empty, fifo_level 0, start_driving 0, stepper_step_in 0, stepper_speed MIN_SPEED, abort 0, residual 0, done_count 0, busy 0, cmd_ready 0 while reset_n low.
REQ-026 Reset mid-move SHALL drop the move; the downstream stepper is reset by the same reset_n.

Structure
REQ-027 Package z_queue_pkg SHALL hold the FSM state enum, ACK_TIMEOUT = 2, and the 64-bit entry type.
REQ-028 FIFO SHALL be a sub-module cmd_fifo (synchronous, DEPTH x 64, level output, flush input).

Verification
REQ-029 Push {0x0000_0010, 4}, stepper model idle -> start_driving pulse 1 cycle, stepper_step_in=0x10, stepper_speed=4, done_count=1 after completion.
REQ-030 Push 8 commands with DEPTH=8 -> cmd_ready=0 after 8th until first pop; 9th write ignored; all 8 executed in order.
REQ-031 Push {0x8000_0000|(-5 & 0x7FFF_FFFF), 0} -> stepper_speed=1, downward move, done_count +1.
REQ-032 Push 100-step move, assert zmax at step 40 -> abort=1, residual=0x3C (60), cmd_ready=0, no further dispatch; flush -> abort=0, fifo_level=0.
REQ-033 zmin held high, push move of 3 -> abort after 2-cycle WAIT_ACK timeout, residual=0x3.
REQ-034 Push count-0 entry -> no start_driving, done_count +1; reset_n low mid-RUN -> all outputs at reset values.
